alu_ctrl_seq: RTL

//  Registered, handshaked ALU control unit for the multi-cycle datapath. Decodes {alu_op, funct}

---
 rtl/alu_ctrl_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_seq.sv
// ALU control decode with MULT/DIV sequencing; result held in a register until consumed.
// Latency: single-cycle ops valid 1 cycle after accept, MULT/DIV valid MULDIV_CYCLES+1 cycles after accept.
// Backpressure: in_ready drops while a result waits on out_ready and for the whole BUSY window.
module alu_ctrl_seq #(
    parameter int CNT_W         = 4,
    parameter int FUNCT_W       = 6,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   alu_cnt,
    output logic               is_muldiv,
    output logic               md_op,
    output logic               md_start,
    output logic               illegal,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, OUT, BUSY} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             is_md;
        logic             md_op;
        logic             ill;
    } res_t;

    localparam logic [CNT_W-1:0] CNT_ADD = CNT_W'(4'b0010);
    localparam logic [CNT_W-1:0] CNT_SUB = CNT_W'(4'b0110);
    localparam logic [CNT_W-1:0] CNT_AND = CNT_W'(4'b0000);
    localparam logic [CNT_W-1:0] CNT_OR  = CNT_W'(4'b0001);
    localparam logic [CNT_W-1:0] CNT_SLT = CNT_W'(4'b0111);
    localparam logic [CNT_W-1:0] CNT_NOR = CNT_W'(4'b1100);

    localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] F_NOR  = FUNCT_W'(6'b100111);
    localparam logic [FUNCT_W-1:0] F_MULT = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] F_DIV  = FUNCT_W'(6'b011010);

    localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] md_cnt, md_cnt_nxt;
    res_t       res_q, dec;
    logic       accept;
    logic       md_start_q, md_start_nxt;

    always_comb begin
        dec = '{cnt: CNT_ADD, is_md: 1'b0, md_op: 1'b0, ill: 1'b0};
        if (alu_op == 2'b00) begin
            dec.cnt = CNT_ADD;
        end else if (alu_op[0]) begin
            dec.cnt = CNT_SUB;
        end else begin
            case (funct)
                F_ADD:   dec.cnt = CNT_ADD;
                F_SUB:   dec.cnt = CNT_SUB;
                F_AND:   dec.cnt = CNT_AND;
                F_OR:    dec.cnt = CNT_OR;
                F_SLT:   dec.cnt = CNT_SLT;
                F_NOR:   dec.cnt = CNT_NOR;
                F_MULT:  dec.is_md = 1'b1;
                F_DIV: begin
                    dec.is_md = 1'b1;
                    dec.md_op = 1'b1;
                end
                default: dec.ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new accept in OUT overrides the return to IDLE, giving back-to-back throughput.
    always_comb begin
        state_nxt    = state;
        md_cnt_nxt   = md_cnt;
        in_ready     = 1'b0;
        md_start_nxt = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            OUT: begin
                in_ready = out_ready;
                if (out_ready) state_nxt = IDLE;
            end
            BUSY: begin
                if (md_cnt == 8'd0) state_nxt = OUT;
                else                md_cnt_nxt = md_cnt - 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
        accept = in_valid & in_ready;
        if (accept) begin
            if (dec.is_md) begin
                state_nxt    = BUSY;
                md_cnt_nxt   = MD_LOAD;
                md_start_nxt = 1'b1;
            end else begin
                state_nxt = OUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt     <= 8'd0;
            md_start_q <= 1'b0;
            res_q      <= '{cnt: CNT_ADD, is_md: 1'b0, md_op: 1'b0, ill: 1'b0};
        end else begin
            md_cnt     <= md_cnt_nxt;
            md_start_q <= md_start_nxt;
            if (accept) res_q <= dec;
        end
    end

    assign out_valid = (state == OUT);
    assign busy      = (state == BUSY);
    assign md_start  = md_start_q;
    assign alu_cnt   = res_q.cnt;
    assign is_muldiv = res_q.is_md;
    assign md_op     = res_q.md_op;
    assign illegal   = res_q.ill;

endmodule
